uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 176000, clk cycles per serial bit (legal range 8..2^20).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal range 1..2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, receive buffer depth (power of two, minimum 2).
REQ-006 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_i  in  1  serial input, asynchronous, idle high.
- data_o  out  DATA_BITS  FIFO head word.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts head word.
- parity_err_o  out  1  one-cycle pulse on parity mismatch.
- frame_err_o  out  1  one-cycle pulse on low stop bit.
- overflow_o  out  1  sticky overflow flag.
- clr_i  in  1  clears overflow_o.
- busy_o  out  1  high whenever state is not IDLE.

Function
REQ-007 SHALL pass rx_i through a 2-flop synchroniser; all sampling uses the synchronised value, and the synchroniser flops reset to 1.
REQ-008 SHALL implement the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-009 IDLE SHALL move to START on a synchronised high-to-low transition, loading the bit counter with CLKS_PER_BIT/2-1.
REQ-010 START, at counter expiry (mid start bit), SHALL return to IDLE with no output if rx is high (false start), otherwise SHALL go to DATA.
REQ-011 DATA SHALL take DATA_BITS samples, one every CLKS_PER_BIT cycles at bit centre, LSB first, then SHALL go to PARITY if PARITY!=0, else to STOP.
REQ-012 PARITY SHALL take one sample, and a mismatch SHALL set an internal error mark (odd: the XOR of data and parity bit must be 1; even: it must be 0).
REQ-013 STOP SHALL take STOP_BITS samples, and any low sample SHALL mark a framing error.
REQ-014 At the final stop sample, a frame with no error SHALL be pushed to the FIFO and the state SHALL return to IDLE.
REQ-015 A frame with a parity error SHALL be dropped and parity_err_o SHALL pulse for 1 cycle.
REQ-016 A frame with a framing error SHALL be dropped and frame_err_o SHALL pulse for 1 cycle; if both errors occur, both SHALL pulse in the same cycle.
REQ-017 On a framing error with rx still low (break), the state SHALL go to BREAK and stay there until rx is high, then go to IDLE; only one frame_err_o pulse SHALL occur per break.
REQ-018 A pushed word SHALL appear on data_o with valid_o high on the cycle after the final stop sample (first-word fall-through).
REQ-019 A pop SHALL occur when valid_o and ready_i are both high; data_o SHALL be held stable while valid_o is high and ready_i is low.
REQ-020 A push when full and not popping SHALL be discarded and SHALL set overflow_o; a push while full and popping in the same cycle SHALL be accepted.
REQ-021 overflow_o SHALL stay set until clr_i is high; a set and clr_i in the same cycle SHALL leave overflow_o set.
REQ-022 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, and the FIFO pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide so that full and empty are distinguished by wrap.

Reset
REQ-023 On rst_n low, reset SHALL be asynchronous; state SHALL be IDLE, counters and FIFO pointers SHALL be 0, and valid_o, busy_o, parity_err_o, frame_err_o and overflow_o SHALL be 0.
REQ-024 data_o SHALL reset to 0.
REQ-025 A reset in mid-frame SHALL discard the partial frame and all buffered words.
REQ-026 After reset release, reception SHALL restart only on the next falling edge seen after rx is high.

Structure
REQ-027 Package uart_pkg SHALL hold the state enum and the parity-mode constants PAR_NONE, PAR_ODD and PAR_EVEN.
REQ-028 The FIFO SHALL be a sub-module, uart_rx_fifo, parameterised by width and depth, with push/pop/full/empty and same-cycle push/pop when full.
REQ-029 Elaboration SHALL fail on an illegal value of any parameter.

Verification
REQ-030 CLKS_PER_BIT=16, 8N1, send 0x55 -> valid_o high with data_o=0x55 exactly 1 cycle after the stop-bit centre, and busy_o low in the following cycle.
REQ-031 rx low for 3 cycles, then high -> no valid_o, no error pulse, and a return to IDLE at the start-bit centre.
REQ-032 PARITY=2, send 0xA3 with parity bit 1 -> parity_err_o pulses once and the FIFO stays empty; the same frame with parity bit 0 -> data_o=0xA3.
REQ-033 rx held low for 30 bit times -> exactly one frame_err_o pulse and no FIFO push; after rx goes high, the next frame 0x3C is received correctly.
REQ-034 FIFO_DEPTH=4, ready_i=0, send 0x01..0x05 -> overflow_o set after the 5th frame, and the pops return 0x01..0x04; clr_i then clears overflow_o.
REQ-035 rst_n asserted mid-data-bit of 0x7E -> all outputs 0 immediately; after release, frame 0x81 -> data_o=0x81 only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Returns 1 when the received parity bit disagrees with the data word.
  // Odd: data XOR parity must be 1.  Even: data XOR parity must be 0.
  function automatic logic parity_bad(input int mode, input logic data_xor,
                                      input logic pbit);
    logic sum;
    sum = data_xor ^ pbit;
    if (mode == PAR_ODD)       parity_bad = ~sum;
    else if (mode == PAR_EVEN) parity_bad = sum;
    else                       parity_bad = 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer: first-word fall-through FIFO with wrap-bit pointers.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_pop;
  logic w_do_push;

  // Equal pointers mean empty; equal index with differing wrap bit means full.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head word is forced to zero when empty so the output is defined after reset.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; data words carry no reset
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, frame FSM with parity/framing/break handling,
// receive FIFO and sticky overflow flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 176000,
  parameter int          DATA_BITS    = 8,
  parameter int          PARITY       = 0,
  parameter int          STOP_BITS    = 1,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overflow_o,
  input  logic                 clr_i,
  output logic                 busy_o
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  // Reject illegal parameter values at elaboration
  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > (1 << 20)) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT out of range 8..2^20");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_rx: DATA_BITS out of range 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_rx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx: STOP_BITS out of range 1..2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  // Synchroniser and edge detection
  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_warm;
  logic       r_rx_prev;
  logic       w_rx;
  logic       w_fall;

  // FSM and datapath
  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [3:0]            r_bit_idx;
  logic [3:0]            w_bit_idx_nxt;
  logic                  r_stop_idx;
  logic                  w_stop_idx_nxt;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  w_shift_nxt;
  logic                  r_par_err;
  logic                  w_par_err_nxt;
  logic                  r_frm_err;
  logic                  w_frm_err_nxt;
  logic                  w_frm_now;
  logic                  w_tick;
  logic                  w_push;
  logic                  w_pulse_par;
  logic                  w_pulse_frm;

  // Outputs and FIFO handshake
  logic                  r_parity_err;
  logic                  r_frame_err;
  logic                  r_overflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [DATA_BITS-1:0]  w_fifo_data;

  assign w_rx   = r_sync2;
  // r_rx_prev only goes high once the synchroniser holds real line values,
  // so a line held low through reset release never looks like a start edge.
  assign w_fall = r_rx_prev && !w_rx;
  assign w_tick = (r_cnt == '0);

  // Two-flop synchroniser, warm-up shift and previous-sample register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_warm    <= 2'b00;
      r_rx_prev <= 1'b0;
    end else begin
      r_sync1   <= rx_i;
      r_sync2   <= r_sync1;
      r_warm    <= {r_warm[0], 1'b1};
      r_rx_prev <= r_warm[1] ? w_rx : 1'b0;
    end
  end

  // FSM state and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_par_err  <= w_par_err_nxt;
      r_frm_err  <= w_frm_err_nxt;
    end
  end

  // Data shift register; contents only matter once a frame completes
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // Next-state, bit-timing and frame-completion logic
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = w_tick ? CNT_FULL : r_cnt - CW'(1);
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_shift_nxt    = r_shift;
    w_par_err_nxt  = r_par_err;
    w_frm_err_nxt  = r_frm_err;
    w_frm_now      = 1'b0;
    w_push         = 1'b0;
    w_pulse_par    = 1'b0;
    w_pulse_frm    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = CNT_HALF;
        end
      end

      ST_START: begin
        if (w_tick) begin
          if (w_rx) begin
            // Line high again at mid start bit: glitch, not a frame
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt   = ST_DATA;
            w_bit_idx_nxt = '0;
            w_par_err_nxt = 1'b0;
            w_frm_err_nxt = 1'b0;
          end
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == LAST_BIT) begin
            w_state_nxt    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            w_stop_idx_nxt = 1'b0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (w_tick) begin
          w_par_err_nxt  = parity_bad(PARITY, ^r_shift, w_rx);
          w_state_nxt    = ST_STOP;
          w_stop_idx_nxt = 1'b0;
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          w_frm_now = r_frm_err || !w_rx;
          if (r_stop_idx == STOP_LAST) begin
            w_pulse_par = r_par_err;
            w_pulse_frm = w_frm_now;
            w_push      = !r_par_err && !w_frm_now;
            w_cnt_nxt   = '0;
            // A low final stop sample means the line is still held low
            w_state_nxt = (w_frm_now && !w_rx) ? ST_BREAK : ST_IDLE;
          end else begin
            w_frm_err_nxt  = w_frm_now;
            w_stop_idx_nxt = 1'b1;
          end
        end
      end

      ST_BREAK: begin
        w_cnt_nxt = '0;
        if (w_rx) w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_pop = !w_empty && ready_i;

  // Receive buffer
  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_shift_nxt),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Error pulses and sticky overflow; a new overflow wins over clr_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_parity_err <= w_pulse_par;
      r_frame_err  <= w_pulse_frm;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (clr_i)                 r_overflow <= 1'b0;
    end
  end

  assign data_o       = w_fifo_data;
  assign valid_o      = !w_empty;
  assign parity_err_o = r_parity_err;
  assign frame_err_o  = r_frame_err;
  assign overflow_o   = r_overflow;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 instance and an even-parity instance.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  // 8N1 instance
  logic       rx0 = 1'b1, ready0 = 1'b0, clr0 = 1'b0;
  logic [7:0] d0;
  logic       v0, pe0, fe0, ov0, b0;

  // Even-parity instance
  logic       rx1 = 1'b1, ready1 = 1'b0, clr1 = 1'b0;
  logic [7:0] d1;
  logic       v1, pe1, fe1, ov1, b1;

  // Monitor state
  int   fe0_cnt = 0, pe0_cnt = 0, pe1_cnt = 0, fe1_cnt = 0;
  int   v0_rise_cyc = -1;
  logic b0_at_rise = 1'b1;
  logic v0_q = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
            .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx0), .data_o(d0), .valid_o(v0),
    .ready_i(ready0), .parity_err_o(pe0), .frame_err_o(fe0),
    .overflow_o(ov0), .clr_i(clr0), .busy_o(b0));

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
            .FIFO_DEPTH(4)) dutp (
    .clk(clk), .rst_n(rst_n), .rx_i(rx1), .data_o(d1), .valid_o(v1),
    .ready_i(ready1), .parity_err_o(pe1), .frame_err_o(fe1),
    .overflow_o(ov1), .clr_i(clr1), .busy_o(b1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fe0) fe0_cnt++;
    if (pe0) pe0_cnt++;
    if (pe1) pe1_cnt++;
    if (fe1) fe1_cnt++;
    if (v0 && !v0_q) begin
      v0_rise_cyc = cyc;
      b0_at_rise  = b0;
    end
    v0_q = v0;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one bit period; t returns the cycle count at the driving edge
  task automatic drive_bit(input int sel, input logic val, output int t);
    @(negedge clk);
    t = cyc;
    if (sel == 0) rx0 = val; else rx1 = val;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d,
                            input bit has_par, input logic pbit,
                            output int t0);
    int t;
    drive_bit(sel, 1'b0, t0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], t);
    if (has_par) drive_bit(sel, pbit, t);
    drive_bit(sel, 1'b1, t);
  endtask

  initial begin
    int t0, t, snap_fe, snap_pe, snap_fe1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", v0, 0);
    check("rst_data", d0, 8'h00);
    check("rst_busy", b0, 0);
    check("rst_ovf", ov0, 0);
    check("rst_perr", pe0, 0);
    check("rst_ferr", fe0, 0);
    idle(4);
    rst_n = 1'b1;
    idle(20);

    // 8N1 frame 0x55: stop-bit centre at the 155th edge after the start bit
    send_frame(0, 8'h55, 0, 1'b0, t0);
    check("x55_latency", v0_rise_cyc - t0, 155);
    check("x55_busy_low", b0_at_rise, 0);
    check("x55_data", d0, 8'h55);
    check("x55_valid", v0, 1);
    idle(5);
    check("x55_hold", d0, 8'h55);
    ready0 = 1'b1;
    idle(1);
    ready0 = 1'b0;
    check("x55_popped", v0, 0);
    idle(10);

    // False start: 3 low cycles, back to IDLE at mid start bit
    snap_fe = fe0_cnt;
    snap_pe = pe0_cnt;
    @(negedge clk);
    t0 = cyc;
    rx0 = 1'b0;
    idle(3);
    rx0 = 1'b1;
    while (cyc < t0 + 10) @(negedge clk);
    check("fs_busy_start", b0, 1);
    @(negedge clk);
    check("fs_busy_idle", b0, 0);
    idle(CPB * 12);
    check("fs_no_valid", v0, 0);
    check("fs_no_ferr", fe0_cnt - snap_fe, 0);
    check("fs_no_perr", pe0_cnt - snap_pe, 0);

    // Even parity: 0xA3 has four ones, parity bit 1 is wrong
    snap_pe  = pe1_cnt;
    snap_fe1 = fe1_cnt;
    send_frame(1, 8'hA3, 1, 1'b1, t0);
    idle(5);
    check("par_bad_pulse", pe1_cnt - snap_pe, 1);
    check("par_bad_noferr", fe1_cnt - snap_fe1, 0);
    check("par_bad_empty", v1, 0);
    send_frame(1, 8'hA3, 1, 1'b0, t0);
    idle(5);
    check("par_ok_valid", v1, 1);
    check("par_ok_data", d1, 8'hA3);
    check("par_ok_nopulse", pe1_cnt - snap_pe, 1);

    // Break: 30 bit times low gives one framing error and no push
    snap_fe = fe0_cnt;
    @(negedge clk);
    rx0 = 1'b0;
    idle(30 * CPB);
    check("brk_busy", b0, 1);
    rx0 = 1'b1;
    idle(20);
    check("brk_one_pulse", fe0_cnt - snap_fe, 1);
    check("brk_no_push", v0, 0);
    check("brk_idle", b0, 0);
    send_frame(0, 8'h3C, 0, 1'b0, t0);
    idle(3);
    check("brk_next_valid", v0, 1);
    check("brk_next_data", d0, 8'h3C);
    ready0 = 1'b1;
    idle(1);
    ready0 = 1'b0;
    idle(10);

    // Overflow: five frames into a depth-4 buffer with no consumer
    for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 0, 1'b0, t0);
    idle(3);
    check("ovf_not_yet", ov0, 0);
    send_frame(0, 8'h05, 0, 1'b0, t0);
    idle(3);
    check("ovf_set", ov0, 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_data", d0, 32'(i));
      ready0 = 1'b1;
      idle(1);
      ready0 = 1'b0;
    end
    check("ovf_drained", v0, 0);
    check("ovf_sticky", ov0, 1);
    clr0 = 1'b1;
    idle(1);
    clr0 = 1'b0;
    check("ovf_cleared", ov0, 0);
    idle(5);

    // Reset mid data bit with a word already buffered
    send_frame(0, 8'h11, 0, 1'b0, t0);
    idle(3);
    drive_bit(0, 1'b0, t);
    drive_bit(0, 1'b0, t);
    drive_bit(0, 1'b1, t);
    drive_bit(0, 1'b1, t);
    @(negedge clk);
    check("mid_busy_pre", b0, 1);
    check("mid_valid_pre", v0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", v0, 0);
    check("mid_rst_data", d0, 8'h00);
    check("mid_rst_busy", b0, 0);
    idle(3);
    rx0 = 1'b1;
    idle(1);
    rst_n = 1'b1;
    idle(10);
    check("mid_rel_idle", v0, 0);
    send_frame(0, 8'h81, 0, 1'b0, t0);
    idle(3);
    check("mid_next_data", d0, 8'h81);
    ready0 = 1'b1;
    idle(1);
    ready0 = 1'b0;
    check("mid_only_one", v0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
